// File: rtl/inst_sram_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_sram_responder_pkg                                         |
// | Purpose  : Shared constants and the response-entry type for the            |
// |            instruction-side SRAM-like responder.                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package inst_sram_responder_pkg;

  // Access size encodings on inst_sram_size. The responder itself ignores
  // size because the master pre-aligns wstrb/wdata; kept for masters/benches.
  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  // Width of one in-flight response entry {valid, is_wr, data}.
  localparam int RESP_ENTRY_WD = 34;

  typedef struct packed {
    logic        valid;
    logic        is_wr;
    logic [31:0] data;
  } resp_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_sram_responder_resp_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_sram_responder_resp_delay_line                             |
// | Purpose  : DEPTH-stage shift pipeline of response entries. Only the valid  |
// |            bits are reset; payload flops are free-running.                 |
// | Ports    : clk, reset (async, active-high)                                 |
// |            in_entry  - entry entering stage 0                              |
// |            out_entry - entry leaving the last stage (in_entry if DEPTH=0)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module inst_sram_responder_resp_delay_line
  import inst_sram_responder_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  resp_entry_t in_entry,
  output resp_entry_t out_entry
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // No extra delay: the caller's own register stage sets the latency.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign out_entry      = in_entry;
    end else begin : g_pipe
      logic [DEPTH-1:0] valid_q, valid_d;
      logic [DEPTH-1:0] is_wr_q, is_wr_d;
      logic [31:0]      data_q [DEPTH];
      logic [31:0]      data_d [DEPTH];

      always_comb begin
        valid_d[0] = in_entry.valid;
        is_wr_d[0] = in_entry.is_wr;
        data_d[0]  = in_entry.data;
        for (int k = 1; k < DEPTH; k++) begin
          valid_d[k] = valid_q[k-1];
          is_wr_d[k] = is_wr_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= '0;
        end else begin
          valid_q <= valid_d;
        end
      end

      always_ff @(posedge clk) begin
        is_wr_q <= is_wr_d;
        data_q  <= data_d;
      end

      always_comb begin
        out_entry.valid = valid_q[DEPTH-1];
        out_entry.is_wr = is_wr_q[DEPTH-1];
        out_entry.data  = data_q[DEPTH-1];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/inst_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_sram_responder                                             |
// | Purpose  : Responder end of the instruction-side SRAM-like bus. Accepts    |
// |            address handshakes, issues them to a synchronous backing        |
// |            memory in the same cycle and returns one in-order data_ok per   |
// |            accepted request 1+RESP_DELAY cycles later.                     |
// | Ports    : clk, reset (async, active-high)                                 |
// |            inst_sram_*  - SRAM-like slave interface (req/addr_ok/data_ok)  |
// |            stall        - forces addr_ok low                               |
// |            mem_*        - synchronous backing memory (1-cycle read)        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int RESP_DELAY = 0,
  parameter int MAX_OUTS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [31:0]       inst_sram_addr,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [31:0]       inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [31:0]       inst_sram_rdata,
  input  logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter wide enough for MAX_OUTS up to 4.
  localparam int CNT_W = 3;

  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_valid_q, issue_valid_d;
  logic             issue_wr_q, issue_wr_d;
  resp_entry_t      head_entry;
  resp_entry_t      tail_entry;

  // Size and the byte-offset/upper address bits play no part in a
  // word-organised memory access.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_size, inst_sram_addr[31:ADDR_W+2],
                           inst_sram_addr[1:0]};

  always_comb begin
    // Compared against the registered count, so a slot freed by data_ok is
    // reusable only from the following cycle. Held low while in reset.
    inst_sram_addr_ok = inst_sram_req && !stall && !reset &&
                        (cnt_q < CNT_W'(MAX_OUTS));
    accept            = inst_sram_req && inst_sram_addr_ok;

    mem_en    = accept;
    mem_we    = (accept && inst_sram_wr) ? inst_sram_wstrb : 4'b0000;
    mem_addr  = inst_sram_addr[ADDR_W+1:2];
    mem_wdata = inst_sram_wdata;

    issue_valid_d = accept;
    issue_wr_d    = inst_sram_wr;

    // One cycle after issue the memory output is valid; writes answer 0.
    head_entry.valid = issue_valid_q;
    head_entry.is_wr = issue_wr_q;
    head_entry.data  = issue_wr_q ? 32'h0 : mem_rdata;

    inst_sram_data_ok = tail_entry.valid;
    inst_sram_rdata   = tail_entry.valid ? tail_entry.data : 32'h0;

    cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(inst_sram_data_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_wr_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      issue_valid_q <= issue_valid_d;
      issue_wr_q    <= issue_wr_d;
    end
  end

  inst_sram_responder_resp_delay_line #(
    .DEPTH (RESP_DELAY)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_entry  (head_entry),
    .out_entry (tail_entry)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_inst_sram_responder                                          |
// | Purpose  : Self-checking bench. Three responders (RESP_DELAY 0/2/3,        |
// |            MAX_OUTS 2) each with a behavioural synchronous memory; a       |
// |            scoreboard queue holds expected {data, due cycle} per accept.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_inst_sram_responder;

  localparam int NI   = 3;
  localparam int AW   = 8;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req       [NI];
  logic          wr        [NI];
  logic [1:0]    size      [NI];
  logic [31:0]   addr      [NI];
  logic [3:0]    wstrb     [NI];
  logic [31:0]   wdata     [NI];
  logic          stall     [NI];
  logic          addr_ok   [NI];
  logic          data_ok   [NI];
  logic [31:0]   rdata     [NI];
  logic          mem_en    [NI];
  logic [3:0]    mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [31:0]   mem_wdata [NI];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [NI][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dly(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
      logic [31:0] mem [256];
      logic [31:0] rd_q;

      always @(posedge clk) begin
        if (mem_en[gi]) begin
          rd_q <= mem[mem_addr[gi]];
          for (int b = 0; b < 4; b++)
            if (mem_we[gi][b]) mem[mem_addr[gi]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
        end
      end

      inst_sram_responder #(
        .ADDR_W     (AW),
        .RESP_DELAY (D),
        .MAX_OUTS   (MAXO)
      ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (req[gi]),
        .inst_sram_wr      (wr[gi]),
        .inst_sram_size    (size[gi]),
        .inst_sram_addr    (addr[gi]),
        .inst_sram_wstrb   (wstrb[gi]),
        .inst_sram_wdata   (wdata[gi]),
        .inst_sram_addr_ok (addr_ok[gi]),
        .inst_sram_data_ok (data_ok[gi]),
        .inst_sram_rdata   (rdata[gi]),
        .stall             (stall[gi]),
        .mem_en            (mem_en[gi]),
        .mem_we            (mem_we[gi]),
        .mem_addr          (mem_addr[gi]),
        .mem_wdata         (mem_wdata[gi]),
        .mem_rdata         (rd_q)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Response monitor: every data_ok must match the head of the scoreboard
  // in instance, data and cycle; an entry past its due cycle is missing.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        if (data_ok[i]) begin
          if (sb.size() == 0 || sb[0].inst != i) begin
            chk("dok_spurious", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rdata", rdata[i], e.data);
            chk("latency", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("dok_missing", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  // One bus cycle on instance i; checks addr_ok against the outstanding
  // count the scoreboard implies and records the expected response.
  task automatic drive(input int i, input logic rq, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic st,
                       output logic acc);
    exp_t        e;
    logic        exp_ok;
    logic [AW-1:0] wa;
    @(posedge clk);
    #1;
    req[i] = rq; wr[i] = w; addr[i] = a; wstrb[i] = s; wdata[i] = d;
    stall[i] = st; size[i] = 2'd2;
    #3;
    wa     = a[AW+1:2];
    exp_ok = rq && !st && (sb.size() < MAXO);
    chk("addr_ok", 32'(addr_ok[i]), 32'(exp_ok));
    acc = addr_ok[i] && rq;
    chk("mem_en", 32'(mem_en[i]), 32'(acc));
    if (acc) begin
      chk("mem_addr", 32'(mem_addr[i]), 32'(wa));
      chk("mem_we", 32'(mem_we[i]), w ? 32'(s) : 32'd0);
      e.inst = i;
      e.due  = cyc + 1 + dly(i);
      e.data = w ? 32'h0 : ref_mem[i][wa];
      sb.push_back(e);
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[i][wa][8*b +: 8] = d[8*b +: 8];
      chk("outstanding_cap", 32'(sb.size() <= MAXO), 32'd1);
    end
  endtask

  task automatic idle(input int i, input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
  endtask

  // Hold req with the same transfer until accepted, bounded.
  task automatic xfer(input int i, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) drive(i, 1'b1, w, a, s, d, 1'b0, acc);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    logic acc;
    int   n_acc;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b1; wr[i] = 1'b0; size[i] = 2'd2; addr[i] = 32'h0;
      wstrb[i] = 4'h0; wdata[i] = 32'h0; stall[i] = 1'b0;
      for (int w = 0; w < 256; w++) ref_mem[i][w] = 32'h0;
    end
    reset = 1'b1;
    #12;
    for (int i = 0; i < NI; i++) begin
      chk("rst_addr_ok", 32'(addr_ok[i]), 32'd0);
      chk("rst_data_ok", 32'(data_ok[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'h0);
      req[i] = 1'b0;
    end
    @(posedge clk); #2 reset = 1'b0;

    // Single read, delay 0.
    xfer(0, 1'b1, 32'h14, 4'hF, 32'h02800C21);
    idle(0, 2);
    xfer(0, 1'b0, 32'h14, 4'h0, 32'h0);
    idle(0, 3);

    // Streaming writes then reads, one per cycle.
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b1, 32'(4*k), 4'hF, 32'h11110000 + 32'(k), 1'b0, acc);
      n_acc += int'(acc);
    end
    chk("stream_wr_accepts", 32'(n_acc), 32'd4);
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 32'(4*k), 4'h0, 32'h0, 1'b0, acc);
      n_acc += int'(acc);
    end
    chk("stream_rd_accepts", 32'(n_acc), 32'd4);
    idle(0, 3);

    // Read-after-write and partial write.
    xfer(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h40, 4'h0, 32'h0);
    xfer(0, 1'b1, 32'h40, 4'h1, 32'h000000AA);
    xfer(0, 1'b0, 32'h40, 4'h0, 32'h0);
    idle(0, 3);
    chk("partial_model", ref_mem[0][16], 32'hDEADBEAA);

    // Stall blocks acceptance.
    drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b1, acc);
    drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b1, acc);
    idle(0, 2);

    // Delay 2: outstanding cap with req held high.
    for (int k = 0; k < 4; k++) xfer(1, 1'b1, 32'(4*k), 4'hF, 32'hA5000000 + 32'(k));
    for (int k = 0; k < 4; k++) xfer(1, 1'b0, 32'(4*k), 4'h0, 32'h0);
    idle(1, 5);

    // In-flight request survives a master flush with stall raised.
    xfer(1, 1'b0, 32'h8, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);

    // Delay 3: async reset with two reads in flight.
    xfer(2, 1'b1, 32'h80, 4'hF, 32'hCAFE0001);
    xfer(2, 1'b1, 32'h84, 4'hF, 32'hCAFE0002);
    idle(2, 6);
    drive(2, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 1'b0, acc);
    chk("pre_rst_acc0", 32'(acc), 32'd1);
    drive(2, 1'b1, 1'b0, 32'h84, 4'h0, 32'h0, 1'b0, acc);
    chk("pre_rst_acc1", 32'(acc), 32'd1);
    idle(2, 2);
    @(posedge clk);
    #1;
    chk("pre_rst_dok", 32'(data_ok[2]), 32'd1);
    req[2] = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_dok", 32'(data_ok[2]), 32'd0);
    chk("mid_rst_addr_ok", 32'(addr_ok[2]), 32'd0);
    chk("mid_rst_rdata", rdata[2], 32'h0);
    sb.delete();
    req[2] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    idle(2, 8);
    xfer(2, 1'b0, 32'h80, 4'h0, 32'h0);
    idle(2, 6);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
